// File: rtl/fp16_align_stage.sv
// ---------------------------------------------------------------------------
// fp16_align_stage
//
// Pre-add operand alignment for the FP16 add/sub datapath. The stage sits
// directly in front of the exponent/mantissa adders. It takes two binary16
// operands and orders them by magnitude. It then right-shifts the smaller
// significand one bit per cycle until both share the larger exponent. Bits
// shifted out are folded into a sticky bit.
//
// Significand layout on both outputs (14 bits):
//   {hidden, frac[9:0], G, R, S}
//
// Optional feature (compile-time macro FP16_ALIGN_SPECIAL_EN):
//   When defined, an operand with an all-ones exponent (Inf/NaN) raises
//   out_special. The small significand is forced to zero and the shift
//   phase is skipped. When undefined, out_special is tied low and exponent
//   31 behaves like any other exponent.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   in_valid       in   1   operand pair valid
//   in_ready       out  1   stage can accept (only while idle)
//   in_a           in   16  operand A, binary16
//   in_b           in   16  operand B, binary16
//   in_sub         in   1   1 = A-B, 0 = A+B
//   out_valid      out  1   aligned result valid
//   out_ready      in   1   downstream accepts
//   out_exp        out  5   effective exponent of larger operand
//   out_man_big    out  14  larger significand, GRS = 000
//   out_man_small  out  14  aligned smaller significand with sticky
//   out_sign_big   out  1   sign of larger operand (B sign flipped for sub)
//   out_eff_sub    out  1   effective operation is a subtraction
//   out_special    out  1   Inf/NaN operand seen (0 without the feature)
// ---------------------------------------------------------------------------
module fp16_align_stage #(
  parameter int EXP_W     = 5,
  parameter int FRAC_W    = 10,
  parameter int MAX_SHIFT = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_a,
  input  logic [15:0]         in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP_W-1:0]    out_exp,
  output logic [FRAC_W+3:0]   out_man_big,
  output logic [FRAC_W+3:0]   out_man_small,
  output logic                out_sign_big,
  output logic                out_eff_sub,
  output logic                out_special
);

  localparam int SIG_W = FRAC_W + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;

  // Captured operands, held for the compare cycle.
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;

  // Remaining shift count. Diffs above MAX_SHIFT are clamped, so 4 bits suffice.
  logic [3:0]  cnt;

  // Compare-cycle decode of the captured operands.
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [EXP_W-1:0]  eff_a, eff_b;
  logic [SIG_W-1:0]  sig_a, sig_b;
  logic              sign_b_eff;
  logic              swap;
  logic [EXP_W-1:0]  eff_big, eff_small;
  logic [SIG_W-1:0]  sig_big, sig_small;
  logic              sign_big;
  logic [EXP_W-1:0]  diff;
  logic [3:0]        shift_amt;
  logic              is_special;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // Operand decode, magnitude ordering and shift-count computation. These
  // only matter in the CMP cycle, but they are evaluated continuously.
  // Ordering uses the raw {exp,frac} magnitude. A denormal (raw exp 0)
  // therefore always ranks below exp 1, even though both have effective
  // exponent 1. The exponent difference uses the effective exponents,
  // because those are what the significands are aligned to.
  always_comb begin
    exp_a      = op_a[FRAC_W +: EXP_W];
    exp_b      = op_b[FRAC_W +: EXP_W];
    frac_a     = op_a[FRAC_W-1:0];
    frac_b     = op_b[FRAC_W-1:0];
    eff_a      = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b      = (exp_b == '0) ? EXP_W'(1) : exp_b;
    sig_a      = {(exp_a != '0), frac_a, 3'b000};
    sig_b      = {(exp_b != '0), frac_b, 3'b000};
    sign_b_eff = op_b[15] ^ op_sub;
    swap       = (op_a[14:0] < op_b[14:0]);

    eff_big    = eff_a;
    eff_small  = eff_b;
    sig_big    = sig_a;
    sig_small  = sig_b;
    sign_big   = op_a[15];
    if (swap) begin
      eff_big   = eff_b;
      eff_small = eff_a;
      sig_big   = sig_b;
      sig_small = sig_a;
      sign_big  = sign_b_eff;
    end

    diff = eff_big - eff_small;
    if (diff > EXP_W'(MAX_SHIFT)) begin
      shift_amt = 4'(MAX_SHIFT);
    end else begin
      shift_amt = diff[3:0];
    end

`ifdef FP16_ALIGN_SPECIAL_EN
    is_special = (&exp_a) | (&exp_b);
`else
    is_special = 1'b0;
`endif
  end

  // Main control and datapath registers. All result outputs are registers.
  // They keep their value after the handshake until the next compare cycle
  // overwrites them. The small significand is shifted in place. While that
  // happens out_valid is low, so downstream never sees the partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_a          <= '0;
      op_b          <= '0;
      op_sub        <= 1'b0;
      cnt           <= '0;
      out_exp       <= '0;
      out_man_big   <= '0;
      out_man_small <= '0;
      out_sign_big  <= 1'b0;
      out_eff_sub   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= in_a;
            op_b   <= in_b;
            op_sub <= in_sub;
            state  <= CMP;
          end
        end

        CMP: begin
          out_exp       <= eff_big;
          out_man_big   <= sig_big;
          out_man_small <= sig_small;
          out_sign_big  <= sign_big;
          out_eff_sub   <= op_a[15] ^ sign_b_eff;
          cnt           <= shift_amt;
          if (is_special) begin
            // Inf/NaN bypasses alignment entirely; the result is decided
            // downstream from out_special, so the small operand is cleared.
            out_man_small <= '0;
            state         <= HOLD;
          end else if (shift_amt == 4'd0) begin
            state <= HOLD;
          end else begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // One position per cycle. The bit leaving position 1 is ORed into
          // the sticky position, so S collects everything shifted out.
          out_man_small <= {1'b0, out_man_small[SIG_W-1:2],
                            out_man_small[1] | out_man_small[0]};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP16_ALIGN_SPECIAL_EN
  // Special flag is registered alongside the other results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_special <= 1'b0;
    end else if (state == CMP) begin
      out_special <= is_special;
    end
  end
`else
  assign out_special = 1'b0;
`endif

endmodule
